// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppu_pkg
// Description : Shared types and constants for the PPU sprite fetch path:
//               fetch-phase encodings, fetch FSM states, slot count,
//               empty secondary-OAM byte value and attribute bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package ppu_pkg;

    localparam int SPR_SLOTS = 8;
    localparam logic [7:0] SOAM_EMPTY = 8'hFF;

    // Attribute byte bit positions
    localparam int ATTR_VFLIP = 7;
    localparam int ATTR_HFLIP = 6;
    localparam int ATTR_PRIO  = 5;

    // Per-slot fetch phases, one dot each
    typedef enum logic [2:0] {
        PH_Y    = 3'd0,  // secondary OAM byte 0
        PH_TILE = 3'd1,  // secondary OAM byte 1
        PH_ATTR = 3'd2,  // secondary OAM byte 2
        PH_X    = 3'd3,  // secondary OAM byte 3
        PH_A0   = 3'd4,  // plane-0 address on the bus
        PH_P0   = 3'd5,  // plane-0 data returned
        PH_A1   = 3'd6,  // plane-1 address on the bus
        PH_P1   = 3'd7   // plane-1 data returned
    } phase_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } fetch_state_t;

    // Evaluation may report more hits than there are slots; clamp to the slot count.
    function automatic logic [3:0] clamp_count(input logic [3:0] count, input logic [3:0] max_slots);
        return (count > max_slots) ? max_slots : count;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_pattern_addr.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pattern_addr
// Description : Combinational pattern-table address calculator for one
//               sprite row: row offset from scanline and Y, vertical flip,
//               8x8 / 8x16 address layout.
// Ports       : scanline - low 8 bits of the line being prepared
//               y, tile, attr - secondary OAM bytes of the sprite
//               size16 - 1 = 8x16 sprites; pt_sel - 8x8 pattern table
//               plane - bit plane (0/1); addr - 14-bit VRAM address
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_pattern_addr
    import ppu_pkg::*;
(
    input  logic [7:0]  scanline,
    input  logic [7:0]  y,
    input  logic [7:0]  tile,
    input  logic [7:0]  attr,
    input  logic        size16,
    input  logic        pt_sel,
    input  logic        plane,
    output logic [13:0] addr
);

    logic [7:0] w_row;
    logic [3:0] w_row_eff;
    logic [6:0] w_unused_attr;
    logic [3:0] w_unused_row;

    // Modulo-256 distance from the sprite top; only the low 4 bits index
    // into a sprite of at most 16 lines.
    assign w_row = scanline - y;

    always_comb begin
        w_row_eff = w_row[3:0];
        if (attr[ATTR_VFLIP]) begin
            if (size16) begin
                w_row_eff = w_row[3:0] ^ 4'hF;
            end else begin
                w_row_eff = {w_row[3], w_row[2:0] ^ 3'b111};
            end
        end
    end

    // 8x16 sprites pick the table with tile[0]; row[3] selects the bottom tile.
    assign addr = size16 ? {1'b0, tile[0], tile[7:1], w_row_eff[3], plane, w_row_eff[2:0]}
                         : {1'b0, pt_sel, tile, plane, w_row_eff[2:0]};

    assign w_unused_attr = attr[6:0];
    assign w_unused_row  = w_row[7:4];

endmodule
`default_nettype wire

// File: rtl/sprite_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sprite_fetch_ctrl
// Description : Horizontal-blank sprite fetch sequencer. For each of the
//               sprite slots it reads four secondary-OAM bytes, issues two
//               pattern reads and pulses the load strobes of that slot.
//               Slots beyond the evaluated count load as transparent.
// Ports       : clk, rst (sync, active-high)
//               dot_tick, fetch_start - dot timing and sequence start
//               scanline, sprite_count, sprite_size16, sprite_pt_sel - setup
//               soam_addr / soam_data - secondary OAM read port
//               vram_addr / vram_rd - pattern fetch request
//               slot_sel, attr_out, x_out, valid_out, *_ld - slot loading
//               busy, done - sequence status
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_fetch_ctrl
    import ppu_pkg::*;
#(
    parameter int NUM_SLOTS = SPR_SLOTS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dot_tick,
    input  logic        fetch_start,
    input  logic [8:0]  scanline,
    input  logic [3:0]  sprite_count,
    input  logic        sprite_size16,
    input  logic        sprite_pt_sel,
    output logic [4:0]  soam_addr,
    input  logic [7:0]  soam_data,
    output logic [13:0] vram_addr,
    output logic        vram_rd,
    output logic [2:0]  slot_sel,
    output logic [3:0]  attr_out,
    output logic [7:0]  x_out,
    output logic        valid_out,
    output logic        attr_ld,
    output logic        x_ld,
    output logic        pattern0_ld,
    output logic        pattern1_ld,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] c_last_slot = 3'(NUM_SLOTS - 1);
    localparam logic [3:0] c_max_count = 4'(NUM_SLOTS);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    phase_t      r_phase;
    phase_t      w_phase_next;
    logic [2:0]  r_slot;
    logic [2:0]  w_slot_next;
    logic [3:0]  r_count;
    logic [4:0]  r_soam_addr;
    logic [7:0]  r_y;
    logic [7:0]  r_tile;
    logic [7:0]  r_attr;
    logic [3:0]  r_attr_out;
    logic [7:0]  r_x_out;
    logic        r_valid_out;
    logic [13:0] r_vram_addr;
    logic        r_vram_rd;

    logic        w_start;
    logic        w_fetch_tick;
    logic        w_last_dot;
    logic        w_slot_valid;
    logic [7:0]  w_byte;
    logic [3:0]  w_attr_nib;
    logic        w_plane;
    logic [13:0] w_pat_addr;
    logic        w_unused_scan;

    // ------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------
    assign w_start      = (r_state == ST_IDLE) && dot_tick && fetch_start;
    assign w_last_dot   = (r_phase == PH_P1) && (r_slot == c_last_slot);
    assign w_slot_valid = ({1'b0, r_slot} < r_count);
    // Empty slots read as all-ones so the slot unit sees a transparent sprite.
    assign w_byte       = w_slot_valid ? soam_data : SOAM_EMPTY;
    assign w_attr_nib   = {w_byte[ATTR_HFLIP], w_byte[ATTR_PRIO], w_byte[1:0]};
    assign w_phase_next = phase_t'(r_phase + 3'd1);
    assign w_slot_next  = (r_phase == PH_P1) ? (r_slot + 3'd1) : r_slot;
    // Plane-1 address is latched on the tick that ends PH_P0.
    assign w_plane      = (r_phase == PH_P0);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and load strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_fetch_tick = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // A reset cycle must not leak a strobe into a slot.
                w_fetch_tick = dot_tick && !rst;
                if (dot_tick && w_last_dot) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        attr_ld     = w_fetch_tick && (r_phase == PH_ATTR);
        x_ld        = w_fetch_tick && (r_phase == PH_X);
        pattern0_ld = w_fetch_tick && (r_phase == PH_P0);
        pattern1_ld = w_fetch_tick && (r_phase == PH_P1);
    end

    // ------------------------------------------------------------------
    // Sequencing counters, byte capture and VRAM request
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase     <= PH_Y;
            r_slot      <= 3'd0;
            r_count     <= 4'd0;
            r_soam_addr <= 5'd0;
            r_y         <= 8'd0;
            r_tile      <= 8'd0;
            r_attr      <= 8'd0;
            r_attr_out  <= 4'd0;
            r_x_out     <= 8'd0;
            r_valid_out <= 1'b0;
            r_vram_addr <= 14'd0;
            r_vram_rd   <= 1'b0;
        end else begin
            r_vram_rd <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_slot      <= 3'd0;
                        r_phase     <= PH_Y;
                        r_soam_addr <= 5'd0;
                        r_count     <= clamp_count(sprite_count, c_max_count);
                    end
                end
                ST_FETCH: begin
                    if (dot_tick) begin
                        case (r_phase)
                            PH_Y:    r_y    <= w_byte;
                            PH_TILE: r_tile <= w_byte;
                            PH_ATTR: begin
                                r_attr      <= w_byte;
                                r_attr_out  <= w_attr_nib;
                                r_valid_out <= w_slot_valid;
                            end
                            PH_X: begin
                                r_x_out     <= w_byte;
                                r_vram_addr <= w_pat_addr;
                                r_vram_rd   <= 1'b1;
                            end
                            PH_P0: begin
                                r_vram_addr <= w_pat_addr;
                                r_vram_rd   <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                        r_phase <= w_phase_next;
                        // The final slot stays put; DONE performs the wrap.
                        if (!w_last_dot) begin
                            r_slot      <= w_slot_next;
                            r_soam_addr <= {w_slot_next, w_phase_next[1:0]};
                        end
                    end
                end
                ST_DONE: begin
                    r_slot  <= 3'd0;
                    r_phase <= PH_Y;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pattern address calculator
    // ------------------------------------------------------------------
    sprite_pattern_addr u_pattern_addr (
        .scanline (scanline[7:0]),
        .y        (r_y),
        .tile     (r_tile),
        .attr     (r_attr),
        .size16   (sprite_size16),
        .pt_sel   (sprite_pt_sel),
        .plane    (w_plane),
        .addr     (w_pat_addr)
    );

    // ------------------------------------------------------------------
    // Outputs. The slot unit latches on the strobe edge, so the freshly
    // read byte is forwarded during the strobe clock and held afterwards.
    // ------------------------------------------------------------------
    assign attr_out  = attr_ld ? w_attr_nib   : r_attr_out;
    assign valid_out = attr_ld ? w_slot_valid : r_valid_out;
    assign x_out     = x_ld    ? w_byte       : r_x_out;

    assign soam_addr = r_soam_addr;
    assign vram_addr = r_vram_addr;
    assign vram_rd   = r_vram_rd;
    assign slot_sel  = r_slot;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

    assign w_unused_scan = scanline[8];

endmodule
`default_nettype wire

// File: tb/tb_sprite_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_fetch_ctrl
// Description : Scoreboard bench for sprite_fetch_ctrl. The stimulus side
//               pushes the strobe events each dot_tick must produce; a
//               monitor pops and compares whenever a strobe, vram_rd or done
//               appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_fetch_ctrl;

    localparam int K_ATTR = 1;
    localparam int K_X    = 2;
    localparam int K_RD   = 3;
    localparam int K_P0   = 4;
    localparam int K_P1   = 5;
    localparam int K_DONE = 6;

    typedef struct {
        int          kind;
        logic [2:0]  slot;
        logic [13:0] addr;
        logic [3:0]  attr;
        logic [7:0]  x;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dot_tick;
    logic        fetch_start;
    logic [8:0]  scanline;
    logic [3:0]  sprite_count;
    logic        sprite_size16;
    logic        sprite_pt_sel;
    logic [4:0]  soam_addr;
    logic [7:0]  soam_data;
    logic [13:0] vram_addr;
    logic        vram_rd;
    logic [2:0]  slot_sel;
    logic [3:0]  attr_out;
    logic [7:0]  x_out;
    logic        valid_out;
    logic        attr_ld;
    logic        x_ld;
    logic        pattern0_ld;
    logic        pattern1_ld;
    logic        busy;
    logic        done;

    logic [7:0]  soam_mem [0:31];
    exp_t        q[$];
    logic [13:0] rd_log[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    int          last_tick_cyc = 0;
    int          done_cyc = -1;

    sprite_fetch_ctrl #(.NUM_SLOTS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .dot_tick     (dot_tick),
        .fetch_start  (fetch_start),
        .scanline     (scanline),
        .sprite_count (sprite_count),
        .sprite_size16(sprite_size16),
        .sprite_pt_sel(sprite_pt_sel),
        .soam_addr    (soam_addr),
        .soam_data    (soam_data),
        .vram_addr    (vram_addr),
        .vram_rd      (vram_rd),
        .slot_sel     (slot_sel),
        .attr_out     (attr_out),
        .x_out        (x_out),
        .valid_out    (valid_out),
        .attr_ld      (attr_ld),
        .x_ld         (x_ld),
        .pattern0_ld  (pattern0_ld),
        .pattern1_ld  (pattern1_ld),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Secondary OAM: synchronous read, data one clk after the address.
    always @(posedge clk) soam_data <= soam_mem[soam_addr];

    // ------------------------------------------------------------------
    // Checking helpers
    // ------------------------------------------------------------------
    task automatic check_eq(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    function automatic logic [37:0] pack(input int k, input logic [2:0] s, input logic [13:0] a,
                                         input logic [3:0] at, input logic [7:0] x, input logic v);
        logic [37:0] p;
        p = '0;
        p[37:30] = 8'(k);
        if (k != K_DONE) p[29:27] = s;
        case (k)
            K_ATTR: begin p[12:9] = at; p[0] = v; end
            K_X:    p[8:1]   = x;
            K_RD:   p[26:13] = a;
            default: begin end
        endcase
        return p;
    endfunction

    task automatic mon_check(input int kind, input string nm);
        exp_t e;
        logic [37:0] act;
        logic [37:0] req;
        n_checks++;
        if (q.size() == 0) begin
            n_fails++;
            $display("FAIL %s: unexpected event at cycle %0d, none required", nm, cyc);
            return;
        end
        e   = q.pop_front();
        act = pack(kind, slot_sel, vram_addr, attr_out, x_out, valid_out);
        req = pack(e.kind, e.slot, e.addr, e.attr, e.x, e.valid);
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %h required %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (attr_ld)     mon_check(K_ATTR, "attr_ld");
            if (x_ld)        mon_check(K_X,    "x_ld");
            if (vram_rd)     begin mon_check(K_RD, "vram_rd"); rd_log.push_back(vram_addr); end
            if (pattern0_ld) mon_check(K_P0,   "pattern0_ld");
            if (pattern1_ld) mon_check(K_P1,   "pattern1_ld");
            if (done)        begin mon_check(K_DONE, "done"); done_cyc = cyc; end
        end
    end

    // ------------------------------------------------------------------
    // Reference model pieces
    // ------------------------------------------------------------------
    function automatic logic [13:0] exp_addr(input logic [8:0] sl, input logic [7:0] y, input logic [7:0] t,
                                             input logic [7:0] at, input bit s16, input bit pt, input bit plane);
        logic [7:0] row;
        logic [3:0] r;
        row = sl[7:0] - y;
        r   = row[3:0];
        if (at[7]) r = s16 ? ~r : {r[3], ~r[2:0]};
        return s16 ? {1'b0, t[0], t[7:1], r[3], plane, r[2:0]} : {1'b0, pt, t, plane, r[2:0]};
    endfunction

    task automatic push_ev(input int kind, input int slot, input logic [13:0] a,
                           input logic [3:0] at, input logic [7:0] x, input logic v);
        exp_t e;
        e.kind = kind; e.slot = 3'(slot); e.addr = a; e.attr = at; e.x = x; e.valid = v;
        q.push_back(e);
    endtask

    // Expected events caused by the k-th dot_tick after the start tick.
    task automatic push_tick(input int k, input int cc, input logic [8:0] sl, input bit s16, input bit pt);
        int slot;
        int ph;
        bit v;
        logic [7:0] y, t, at, x;
        slot = (k - 1) / 8;
        ph   = (k - 1) % 8;
        v    = (slot < cc);
        y    = v ? soam_mem[slot*4 + 0] : 8'hFF;
        t    = v ? soam_mem[slot*4 + 1] : 8'hFF;
        at   = v ? soam_mem[slot*4 + 2] : 8'hFF;
        x    = v ? soam_mem[slot*4 + 3] : 8'hFF;
        case (ph)
            2: push_ev(K_ATTR, slot, 14'd0, {at[6], at[5], at[1:0]}, 8'd0, v);
            3: begin
                push_ev(K_X,  slot, 14'd0, 4'd0, x, 1'b0);
                push_ev(K_RD, slot, exp_addr(sl, y, t, at, s16, pt, 1'b0), 4'd0, 8'd0, 1'b0);
            end
            5: begin
                push_ev(K_P0, slot, 14'd0, 4'd0, 8'd0, 1'b0);
                push_ev(K_RD, slot, exp_addr(sl, y, t, at, s16, pt, 1'b1), 4'd0, 8'd0, 1'b0);
            end
            7: push_ev(K_P1, slot, 14'd0, 4'd0, 8'd0, 1'b0);
            default: begin end
        endcase
        if (k == 64) push_ev(K_DONE, 0, 14'd0, 4'd0, 8'd0, 1'b0);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic do_tick(input int gap, input bit start);
        @(posedge clk); #1;
        dot_tick = 1'b1; fetch_start = start; last_tick_cyc = cyc;
        @(posedge clk); #1;
        dot_tick = 1'b0; fetch_start = 1'b0;
        repeat (gap - 2) @(posedge clk);
    endtask

    function automatic int pick_gap(input int gap);
        return (gap == 0) ? int'($urandom_range(2, 6)) : gap;
    endfunction

    // gap 0 = random 2..6 clk; n_ticks < 64 leaves the sequence mid-flight.
    task automatic run_seq(input int cnt, input bit s16, input bit pt, input logic [8:0] sl,
                           input int gap, input int n_ticks, input int dup_at);
        int cc;
        cc = (cnt > 8) ? 8 : cnt;
        sprite_count = 4'(cnt); sprite_size16 = s16; sprite_pt_sel = pt; scanline = sl;
        rd_log.delete();
        done_cyc = -1;
        @(posedge clk); #1;
        check_eq("busy_before_start", 32'(busy), 32'd0);
        dot_tick = 1'b1; fetch_start = 1'b1;
        @(posedge clk); #1;
        dot_tick = 1'b0; fetch_start = 1'b0;
        check_eq("busy_rise", 32'(busy), 32'd1);
        repeat (pick_gap(gap) - 2) @(posedge clk);
        for (int k = 1; k <= n_ticks; k++) begin
            push_tick(k, cc, sl, s16, pt);
            do_tick(pick_gap(gap), (k == dup_at));
        end
        if (n_ticks == 64) begin
            repeat (3) @(posedge clk);
            #1;
            check_eq("done_latency", 32'(done_cyc), 32'(last_tick_cyc + 1));
            check_eq("busy_after_done", 32'(busy), 32'd0);
            check_eq("queue_drained", 32'(q.size()), 32'd0);
        end
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 32; i++) soam_mem[i] = 8'(i * 37 + 5);
    endtask

    task automatic set_slot(input int s, input logic [7:0] y, input logic [7:0] t,
                            input logic [7:0] at, input logic [7:0] x);
        soam_mem[s*4 + 0] = y; soam_mem[s*4 + 1] = t;
        soam_mem[s*4 + 2] = at; soam_mem[s*4 + 3] = x;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; dot_tick = 1'b0; fetch_start = 1'b0; scanline = 9'd0;
        sprite_count = 4'd0; sprite_size16 = 1'b0; sprite_pt_sel = 1'b0;
        fill_mem();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("reset_soam_addr", 32'(soam_addr), 32'd0);
        check_eq("reset_vram_addr", 32'(vram_addr), 32'd0);
        check_eq("reset_outputs", 32'({slot_sel, attr_out, x_out, valid_out}), 32'd0);
        check_eq("reset_strobes", 32'({attr_ld, x_ld, pattern0_ld, pattern1_ld, vram_rd}), 32'd0);
        check_eq("reset_status", 32'({busy, done}), 32'd0);

        // Single visible sprite, 8x8, table 1: rows 13-10 = 3.
        fill_mem();
        set_slot(0, 8'd10, 8'h42, 8'h01, 8'd100);
        run_seq(1, 1'b0, 1'b1, 9'd13, 2, 64, 0);
        check_eq("basic_plane0_addr", 32'(rd_log[0]), 32'h1423);
        check_eq("basic_plane1_addr", 32'(rd_log[1]), 32'h142B);

        // Vertical flip 8x8: row 3 becomes 4.
        fill_mem();
        set_slot(0, 8'd10, 8'h42, 8'h80, 8'd50);
        run_seq(2, 1'b0, 1'b1, 9'd13, 3, 64, 0);
        check_eq("vflip_plane0_addr", 32'(rd_log[0]), 32'h1424);
        check_eq("vflip_plane1_addr", 32'(rd_log[1]), 32'h142C);

        // 8x16, tile 0x43, row 9: {0,1,0x21,1,p,001}; flipped row 6.
        fill_mem();
        set_slot(0, 8'd4, 8'h43, 8'h00, 8'd20);
        set_slot(1, 8'd4, 8'h43, 8'h80, 8'd30);
        run_seq(2, 1'b1, 1'b0, 9'd13, 0, 64, 0);
        check_eq("tall_plane0_addr", 32'(rd_log[0]), 32'h1431);
        check_eq("tall_plane1_addr", 32'(rd_log[1]), 32'h1439);
        check_eq("tall_vflip_addr",  32'(rd_log[2]), 32'h1426);

        // No sprites: every slot transparent.
        fill_mem();
        run_seq(0, 1'b0, 1'b0, 9'd100, 2, 64, 0);
        check_eq("empty_rd_count", 32'(rd_log.size()), 32'd16);

        // Count above 8 clamps; a second fetch_start mid-sequence is ignored.
        fill_mem();
        run_seq(12, 1'b0, 1'b1, 9'd200, 0, 64, 20);
        check_eq("clamp_rd_count", 32'(rd_log.size()), 32'd16);

        // Reset at slot 4 phase 5: nothing more may come out.
        fill_mem();
        run_seq(8, 1'b1, 1'b1, 9'd77, 2, 37, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_soam_addr", 32'(soam_addr), 32'd0);
        for (int i = 0; i < 12; i++) do_tick(2, 1'b0);
        check_eq("abort_queue", 32'(q.size()), 32'd0);

        // Fresh sequence after the abort starts again at slot 0.
        set_slot(0, 8'd70, 8'h10, 8'h23, 8'd8);
        run_seq(3, 1'b0, 1'b0, 9'd77, 0, 64, 0);
        check_eq("restart_plane0_addr", 32'(rd_log[0]), 32'h0107);

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
